icache_controller: RTL and testbench
====================================

// Module: icache_controller
// PURPOSE
//  Direct-mapped instruction cache and miss sequencer between the fetch unit and i_memory.
//  Hits return one 32-bit instruction in the same cycle. Misses fetch a whole 128-bit block
//  (4 instructions) from i_memory over its read/busywait handshake, then fill the line.
//  Also provides a whole-cache flush and saturating hit/miss counters for profiling.
// PARAMETERS
//  ADDRESS_WIDTH      32  byte-address width of cpu_address
//  INSTRUCTION_WIDTH  32  instruction width; a block is 4*INSTRUCTION_WIDTH bits
//  NUM_LINES          8   cache lines, power of 2; INDEX_BITS = log2(NUM_LINES)
//  COUNTER_WIDTH      16  width of hit_count and miss_count
// PORTS
//  clock          in   1      single clock, rising edge
//  reset          in   1      asynchronous, active-high
//  cpu_read       in   1      fetch request, held until cpu_busywait is low
//  cpu_address    in   32     byte address; [3:2] word, [3+INDEX_BITS:4] index, rest tag; [1:0] ignored
//  cpu_instruction out 32     selected word on a hit, else 0
//  cpu_busywait   out  1      1 = stall fetch
//  flush          in   1      one-cycle pulse, invalidates all lines
//  mem_read       out  1      i_memory read request
//  mem_address    out  28     block address = cpu_address[31:4]
//  mem_readdata   in   128    block; word n is bits [32n+31:32n]
//  mem_busywait   in   1      i_memory busy
//  hit_count      out  16     saturating hit counter
//  miss_count     out  16     saturating miss counter
// BEHAVIOUR
//  Storage: per line valid bit, tag, 128-bit data. Only valid, state, flags and counters reset.
//  Reset (async): state=IDLE, all valid=0, mem_read=0, counters=0, flush_pending=0.
//   Combinational outputs then give cpu_busywait=cpu_read and cpu_instruction=0.
//  hit = cpu_read & valid[index] & (tag[index]==cpu_tag) & state==IDLE. Combinational, 0 latency.
//  cpu_busywait = cpu_read & ~hit. mem_address is combinational from cpu_address.
//  FSM (3 states):
//   IDLE: on a posedge with cpu_read & ~hit & ~flush_pending, go to MEM_READ and count a miss.
//   MEM_READ: mem_read=1 (mem_read is 0 in every other state).
//    The first posedge in this state always stays. Go to UPDATE at the first later posedge
//    where mem_busywait==0.
//   UPDATE: one cycle. At the posedge, write data, tag and valid=1 for the index, then go
//    to IDLE. The held request hits in the following cycle.
//  A miss costs mem latency + 2 cycles. cpu_address must be stable while cpu_busywait=1.
//  Counters:
//   miss_count +1 on each IDLE->MEM_READ transition.
//   hit_count +1 on each IDLE posedge with hit, except the first IDLE cycle after UPDATE
//    (the refill completion is not a hit).
//   Both counters saturate at all-ones.
//  Flush:
//   In IDLE, all valid bits clear at that posedge, and cpu_busywait=1 in that cycle.
//   In MEM_READ or UPDATE, flush sets flush_pending. The fill still completes, then all
//    valid bits clear on the first IDLE posedge; no miss is started in that cycle.
//  Simultaneous hit and flush in IDLE: flush wins; the access is stalled and then misses.
//  Reset during MEM_READ: mem_read drops at once and the partial fill is discarded.
//   An i_memory access already in flight is not cancelled; the bench must reset i_memory too.
//  Same-index different-tag accesses evict (conflict miss); there is no replacement choice.
// TESTING
//  1 Reset, read 0x00 -> miss_count=1, mem_read=1, mem_address=0x0; after mem returns block:
//    cpu_instruction=0x00040019, busywait low, hit_count=0.
//  2 Then read 0x04, 0x08, 0x0C -> same-cycle hits 0x00050023, 0x02060405, 0x0000005A;
//    hit_count=3, mem_read stays 0.
//  3 Read 0x80 (index 0, tag 1) -> miss, mem_address=0x8, line 0 replaced;
//    re-read 0x00 -> miss again, miss_count=3.
//  4 Flush pulse in IDLE, then read 0x04 -> miss; flush during MEM_READ -> fill completes,
//    next read of the same address misses.
//  5 Assert reset mid-MEM_READ -> mem_read=0, cpu_busywait=cpu_read, counters 0;
//    re-read 0x00 -> fresh miss.
//  6 Force hit_count to 0xFFFE, issue 3 hits -> hit_count holds at 0xFFFF.

Source files
------------

// File: rtl/icache_controller.sv
// Direct-mapped instruction cache with a block-refill miss sequencer, whole-cache flush
// and saturating hit/miss profiling counters.
//   state    | meaning
//   IDLE     | lookup; hits served combinationally, misses start a refill
//   MEM_READ | block request held on i_memory until it stops signalling busy
//   UPDATE   | fetched block, tag and valid written into the indexed line
module icache_controller #(
   parameter int ADDRESS_WIDTH     = 32,
   parameter int INSTRUCTION_WIDTH = 32,
   parameter int NUM_LINES         = 8,
   parameter int COUNTER_WIDTH     = 16
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           cpu_read,
   input  logic [ADDRESS_WIDTH-1:0]       cpu_address,
   output logic [INSTRUCTION_WIDTH-1:0]   cpu_instruction,
   output logic                           cpu_busywait,
   input  logic                           flush,
   output logic                           mem_read,
   output logic [ADDRESS_WIDTH-5:0]       mem_address,
   input  logic [4*INSTRUCTION_WIDTH-1:0] mem_readdata,
   input  logic                           mem_busywait,
   output logic [COUNTER_WIDTH-1:0]       hit_count,
   output logic [COUNTER_WIDTH-1:0]       miss_count
);
   localparam int INDEX_BITS  = $clog2(NUM_LINES);
   localparam int TAG_BITS    = ADDRESS_WIDTH - 4 - INDEX_BITS;
   localparam int BLOCK_WIDTH = 4 * INSTRUCTION_WIDTH;

   typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

   state_t                   state;
   state_t                   state_next;
   logic [NUM_LINES-1:0]     valid;
   logic [TAG_BITS-1:0]      tags [NUM_LINES];
   logic [BLOCK_WIDTH-1:0]   data [NUM_LINES];
   logic [BLOCK_WIDTH-1:0]   fill_buf;
   logic                     flush_pending;
   logic                     first_wait;
   logic                     after_fill;

   logic [TAG_BITS-1:0]      cpu_tag;
   logic [INDEX_BITS-1:0]    index;
   logic [1:0]               word;
   logic                     tag_match;
   logic                     hit;
   logic                     start_miss;
   logic [BLOCK_WIDTH-1:0]   line_data;
   logic                     unused_byte_bits;

   assign cpu_tag          = cpu_address[ADDRESS_WIDTH-1 -: TAG_BITS];
   assign index            = cpu_address[4 +: INDEX_BITS];
   assign word             = cpu_address[3:2];
   assign unused_byte_bits = ^cpu_address[1:0];

   assign line_data   = data[index];
   assign tag_match   = valid[index] && (tags[index] == cpu_tag);
   // A flush in the same cycle beats a hit: the access stalls and later misses.
   assign hit         = cpu_read && tag_match && (state == IDLE) && !flush;
   assign start_miss  = (state == IDLE) && cpu_read && !hit && !flush_pending;

   assign cpu_busywait = cpu_read && !hit;
   assign mem_read     = (state == MEM_READ);
   assign mem_address  = cpu_address[ADDRESS_WIDTH-1:4];

   always_comb begin
      cpu_instruction = '0;
      if (hit) begin
         case (word)
            2'd0:    cpu_instruction = line_data[0*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH];
            2'd1:    cpu_instruction = line_data[1*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH];
            2'd2:    cpu_instruction = line_data[2*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH];
            default: cpu_instruction = line_data[3*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH];
         endcase
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (start_miss) state_next = MEM_READ;
         MEM_READ: if (!first_wait && !mem_busywait) state_next = UPDATE;
         UPDATE:   state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         valid         <= '0;
         flush_pending <= 1'b0;
         first_wait    <= 1'b0;
         after_fill    <= 1'b0;
      end else begin
         state      <= state_next;
         first_wait <= start_miss;
         after_fill <= (state == UPDATE);

         if (state == IDLE) begin
            flush_pending <= 1'b0;
            if (flush || flush_pending)
               valid <= '0;
         end else begin
            if (flush)
               flush_pending <= 1'b1;
            if (state == UPDATE)
               valid[index] <= 1'b1;
         end
      end
   end

   // The refill completion cycle is not a hit, hence after_fill.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (hit && !after_fill && (hit_count != '1))
            hit_count <= hit_count + 1'b1;
         if (start_miss && (miss_count != '1))
            miss_count <= miss_count + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if ((state == MEM_READ) && (state_next == UPDATE))
         fill_buf <= mem_readdata;
      if (state == UPDATE) begin
         data[index] <= fill_buf;
         tags[index] <= cpu_tag;
      end
   end
endmodule

// File: tb/tb_icache_controller.sv
// Bench for icache_controller: directed fetch vectors, an i_memory model, and a
// scoreboard queue of expected instructions popped by an independent monitor.
module tb_icache_controller;
   logic          clock = 1'b0;
   logic          reset;
   logic          cpu_read;
   logic [31:0]   cpu_address;
   logic [31:0]   cpu_instruction;
   logic          cpu_busywait;
   logic          flush;
   logic          mem_read;
   logic [27:0]   mem_address;
   logic [127:0]  mem_readdata;
   logic          mem_busywait;
   logic [15:0]   hit_count;
   logic [15:0]   miss_count;

   int            checks   = 0;
   int            failures = 0;
   int            mem_lat  = 3;
   int            mem_cnt  = 0;
   bit            mem_seen;
   logic [31:0]   exp_q [$];

   icache_controller dut (
      .clock(clock), .reset(reset), .cpu_read(cpu_read), .cpu_address(cpu_address),
      .cpu_instruction(cpu_instruction), .cpu_busywait(cpu_busywait), .flush(flush),
      .mem_read(mem_read), .mem_address(mem_address), .mem_readdata(mem_readdata),
      .mem_busywait(mem_busywait), .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clock = ~clock;

   // Block 0 holds the known program words; other blocks hold an address-derived pattern.
   function automatic logic [31:0] exp_word(input logic [31:0] a);
      logic [31:0] w;
      if (a[31:4] == 28'h0) begin
         case (a[3:2])
            2'd0:    w = 32'h00040019;
            2'd1:    w = 32'h00050023;
            2'd2:    w = 32'h02060405;
            default: w = 32'h0000005A;
         endcase
      end else begin
         w = 32'hA0000000 | {4'h0, a[23:4], 8'h00} | {30'h0, a[3:2]};
      end
      return w;
   endfunction

   function automatic logic [127:0] block_of(input logic [27:0] ba);
      logic [127:0] b;
      for (int n = 0; n < 4; n++)
         b[32*n +: 32] = exp_word({ba, n[1:0], 2'b00});
      return b;
   endfunction

   always @(negedge clock) begin
      if (reset || !mem_read) begin
         mem_cnt      = 0;
         mem_busywait = 1'b0;
      end else if (mem_cnt >= mem_lat) begin
         mem_busywait = 1'b0;
         mem_readdata = block_of(mem_address);
      end else begin
         mem_busywait = 1'b1;
         mem_cnt++;
      end
   end

   always @(negedge clock) begin
      if (!reset && cpu_read && !cpu_busywait) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_response addr=%h got=%h", cpu_address, cpu_instruction);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (cpu_instruction !== e) begin
               failures++;
               $display("FAIL instruction addr=%h got=%h expected=%h", cpu_address, cpu_instruction, e);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", name, act, exp);
      end
   endtask

   // Called and returns at posedge+1; holds the request until the cache answers.
   task automatic fetch(input logic [31:0] a, input int exp_stall, input bit fl_first, input bit fl_mid);
      int stall;
      bit done;
      stall    = 0;
      done     = 1'b0;
      mem_seen = 1'b0;
      cpu_address = a;
      cpu_read    = 1'b1;
      flush       = fl_first;
      exp_q.push_back(exp_word(a));
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clock);
         if (!cpu_busywait) begin
            done = 1'b1;
         end else begin
            stall++;
            if (mem_read && !mem_seen) begin
               mem_seen = 1'b1;
               chk("mem_address", 32'(mem_address), 32'(a[31:4]));
               if (fl_mid) flush = 1'b1;
            end
            if (flush) begin
               @(posedge clock);
               #1 flush = 1'b0;
            end
         end
      end
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL fetch_timeout addr=%h got=busy expected=response", a);
         exp_q.delete();
      end
      if (exp_stall >= 0) chk("stall_cycles", stall, exp_stall);
      @(posedge clock);
      #1 cpu_read = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset        = 1'b1;
      cpu_read     = 1'b1;
      cpu_address  = 32'h0;
      flush        = 1'b0;
      mem_readdata = '0;
      mem_busywait = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("reset_busywait", 32'(cpu_busywait), 32'd1);
      chk("reset_instruction", cpu_instruction, 32'h0);
      chk("reset_mem_read", 32'(mem_read), 32'd0);
      chk("reset_counts", {hit_count, miss_count}, 32'h0);
      cpu_read = 1'b0;
      reset    = 1'b0;
      @(posedge clock);
      #1;

      // cold miss on block 0, then same-line hits
      mem_lat = 3;
      fetch(32'h00, 6, 0, 0);
      chk("t1_mem_read_seen", 32'(mem_seen), 32'd1);
      chk("t1_miss_count", 32'(miss_count), 32'd1);
      chk("t1_hit_count", 32'(hit_count), 32'd0);
      fetch(32'h04, 0, 0, 0);
      fetch(32'h08, 0, 0, 0);
      fetch(32'h0C, 0, 0, 0);
      chk("t2_mem_read_seen", 32'(mem_seen), 32'd0);
      chk("t2_hit_count", 32'(hit_count), 32'd3);

      // conflict eviction on index 0
      fetch(32'h80, 6, 0, 0);
      fetch(32'h00, 6, 0, 0);
      chk("t3_miss_count", 32'(miss_count), 32'd3);

      // flush together with a would-be hit, then flush while refilling
      fetch(32'h04, 6, 1, 0);
      chk("t4_flush_idle_miss", 32'(miss_count), 32'd4);
      fetch(32'h10, 6, 0, 1);
      chk("t4_fill_miss", 32'(miss_count), 32'd5);
      fetch(32'h10, 6, 0, 0);
      chk("t4_refetch_miss", 32'(miss_count), 32'd6);
      chk("t4_hit_count", 32'(hit_count), 32'd3);

      // reset while the refill is outstanding
      cpu_address = 32'h20;
      cpu_read    = 1'b1;
      repeat (2) @(negedge clock);
      chk("t5_mem_read_before", 32'(mem_read), 32'd1);
      reset = 1'b1;
      #1;
      chk("t5_mem_read", 32'(mem_read), 32'd0);
      chk("t5_busywait", 32'(cpu_busywait), 32'd1);
      chk("t5_counts", {hit_count, miss_count}, 32'h0);
      cpu_read = 1'b0;
      #1;
      chk("t5_busywait_idle", 32'(cpu_busywait), 32'd0);
      @(posedge clock);
      #1 reset = 1'b0;
      mem_lat = 0;
      fetch(32'h00, 4, 0, 0);
      chk("t5_fresh_miss", 32'(miss_count), 32'd1);
      chk("t5_hit_count", 32'(hit_count), 32'd0);

      // saturate the hit counter with a long stream of hits
      cpu_address = 32'h04;
      cpu_read    = 1'b1;
      for (int i = 0; i < 65534; i++) begin
         exp_q.push_back(32'h00050023);
         @(posedge clock);
         #1;
      end
      cpu_read = 1'b0;
      chk("t6_hit_fffe", 32'(hit_count), 32'h0000FFFE);
      fetch(32'h04, 0, 0, 0);
      fetch(32'h08, 0, 0, 0);
      fetch(32'h0C, 0, 0, 0);
      chk("t6_hit_sat", 32'(hit_count), 32'h0000FFFF);
      chk("t6_miss_count", 32'(miss_count), 32'd1);
      chk("scoreboard_drained", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
